// File: rtl/arb_pkg.sv
// Shared defaults and width helpers for the request-queue / round-robin arbiter slice.
package arb_pkg;

  localparam int ARB_WIDTH_DEF  = 8;
  localparam int DATA_WIDTH_DEF = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_sync_fifo.sv
// Single-port synchronous FIFO: one per requester, head always visible, no bypass.
module arb_sync_fifo
  import arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_WIDTH-1:0]    i_data,
  output logic [DATA_WIDTH-1:0]    o_head,
  output logic [clog2(DEPTH):0]    o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_push;
  logic                  w_pop;

  // A full FIFO refuses the push even when it is popped in the same cycle.
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == {CNT_W{1'b0}});
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/arb_req_queue.sv
// Per-port request queues feeding a round-robin arbiter, with a registered,
// back-pressured output stage and a sticky grant-protocol error flag.
module arb_req_queue
  import arb_pkg::*;
#(
  parameter int ARB_WIDTH  = ARB_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [ARB_WIDTH-1:0]            i_wr_valid,
  output logic [ARB_WIDTH-1:0]            o_wr_ready,
  input  logic [ARB_WIDTH*DATA_WIDTH-1:0] i_wr_data,
  output logic [ARB_WIDTH-1:0]            o_req,
  input  logic [ARB_WIDTH-1:0]            i_grant,
  input  logic                            i_ag,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic                            o_data_valid,
  output logic [idx_width(ARB_WIDTH)-1:0] o_data_port,
  input  logic                            i_out_ready,
  output logic                            o_err
);

  localparam int PORT_W = idx_width(ARB_WIDTH);
  localparam int CNT_W  = clog2(FIFO_DEPTH) + 1;

  logic [ARB_WIDTH-1:0]            w_full;
  logic [ARB_WIDTH-1:0]            w_empty;
  logic [ARB_WIDTH-1:0]            w_push;
  logic [ARB_WIDTH-1:0]            w_pop;
  logic [ARB_WIDTH*CNT_W-1:0]      w_count;
  logic [ARB_WIDTH*DATA_WIDTH-1:0] w_heads;
  logic                            w_can_issue;
  logic                            w_onehot;
  logic                            w_grant_ok;
  logic [DATA_WIDTH-1:0]           w_sel_data;
  logic [PORT_W-1:0]               w_sel_port;

  logic [DATA_WIDTH-1:0]           r_data;
  logic [PORT_W-1:0]               r_data_port;
  logic                            r_data_valid;
  logic                            r_err;

  assign w_can_issue = ~r_data_valid | i_out_ready;

  for (genvar g = 0; g < ARB_WIDTH; g++) begin : g_port
    arb_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_data  (i_wr_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_head  (w_heads[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_count (w_count[g*CNT_W +: CNT_W]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );

    assign w_push[g] = i_wr_valid[g] & ~w_full[g];
    assign o_req[g]  = (w_count[g*CNT_W +: CNT_W] != {CNT_W{1'b0}}) & w_can_issue;
    assign w_pop[g]  = w_grant_ok & i_grant[g] & ~w_empty[g];
  end

  assign o_wr_ready = ~w_full;

  // A grant counts only when strobed, exactly one-hot and aimed at a live request.
  assign w_onehot   = (i_grant != {ARB_WIDTH{1'b0}}) &&
                      ((i_grant & (i_grant - ARB_WIDTH'(1))) == {ARB_WIDTH{1'b0}});
  assign w_grant_ok = i_ag & w_onehot & (|(i_grant & o_req));

  always_comb begin
    w_sel_data = {DATA_WIDTH{1'b0}};
    w_sel_port = {PORT_W{1'b0}};
    for (int p = 0; p < ARB_WIDTH; p++) begin
      if (i_grant[p]) begin
        w_sel_data = w_heads[p*DATA_WIDTH +: DATA_WIDTH];
        w_sel_port = PORT_W'(p);
      end else begin
        w_sel_data = w_sel_data;
        w_sel_port = w_sel_port;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data       <= {DATA_WIDTH{1'b0}};
      r_data_port  <= {PORT_W{1'b0}};
      r_data_valid <= 1'b0;
    end else if (w_grant_ok) begin
      r_data       <= w_sel_data;
      r_data_port  <= w_sel_port;
      r_data_valid <= 1'b1;
    end else if (i_out_ready) begin
      r_data       <= r_data;
      r_data_port  <= r_data_port;
      r_data_valid <= 1'b0;
    end else begin
      r_data       <= r_data;
      r_data_port  <= r_data_port;
      r_data_valid <= r_data_valid;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (i_ag & ~w_grant_ok) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign o_data       = r_data;
  assign o_data_port  = r_data_port;
  assign o_data_valid = r_data_valid;
  assign o_err        = r_err;

endmodule
